freq_range_sequencer: RTL and testbench
=======================================

FREQ_RANGE_SEQUENCER -- requirements
Module: freq_range_sequencer

Interface
REQ-001 Parameters SHALL be: COUNT_WIDTH, 32, count/result width; LOG_MAX, 16, max exponent of Ncycles; INIT_LOG, 0, exponent loaded at reset/enable; MIN_COUNT, 12500, lower in-range bound (clocks); MAX_COUNT, 12500000, upper in-range bound; TIMEOUT, 125000000, clocks without meas_done before no-signal; DISCARD, 1, measurements dropped after each Ncycles change.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 enable  in  1  run sequencer; low = IDLE.
REQ-005 meas_done  in  1  one-cycle pulse, counter has updated count_in this cycle.
REQ-006 count_in  in  COUNT_WIDTH  clocks counted over the last Ncycles input periods.
REQ-007 ncycles_out  out  COUNT_WIDTH  Ncycles driven to counter, = 1 << log_n.
REQ-008 result_count / result_ncycles  out  COUNT_WIDTH each  published count and the Ncycles it was taken with.
REQ-009 result_valid  out  1 / result_ready  in  1  valid/ready output handshake.
REQ-010 no_signal  out  1  timeout flag. overrun  out  1  sticky lost-result flag.

Function
REQ-011 FSM states SHALL be IDLE, SETTLE, MEASURE; enable low in any state -> IDLE next cycle, log_n := INIT_LOG.
REQ-012 IDLE with enable high -> SETTLE, discard counter := DISCARD, timeout counter := 0.
REQ-013 SETTLE: each meas_done decrements discard counter, count_in ignored; when counter is 0 (or DISCARD=0) -> MEASURE.
REQ-014 MEASURE on meas_done: count_in < MIN_COUNT and log_n < LOG_MAX -> log_n+1, SETTLE; count_in > MAX_COUNT and log_n > 0 -> log_n-1, SETTLE; otherwise publish, stay MEASURE.
REQ-015 At log_n limits out-of-range counts SHALL be published unchanged (no wrap of log_n).
REQ-016 Publish: result_count := count_in, result_ncycles := ncycles_out, result_valid := 1, one clock after meas_done.
REQ-017 result_valid SHALL hold, data stable, until clock with result_valid && result_ready; then clears unless a publish occurs same cycle.
REQ-018 Publish while result_valid && !result_ready: overwrite with new data, overrun := 1; publish same cycle as handshake: no overrun.
REQ-019 overrun clears only on reset or enable rising edge.
REQ-020 Timeout counter counts in SETTLE/MEASURE, clears on meas_done and state entry; on reaching TIMEOUT-1: no_signal := 1, log_n := 0, -> SETTLE with discard reload.
REQ-021 no_signal clears on the next publish; it SHALL NOT affect result_valid.
REQ-022 ncycles_out SHALL update the clock after a log_n change; comparisons unsigned, full COUNT_WIDTH.
REQ-023 enable dropped mid-operation: pending result_valid/data retained until handshake; no new publish in IDLE.

Reset
REQ-024 aresetn low at clock edge: state IDLE, log_n := INIT_LOG (ncycles_out = 1), result_valid, result_count, result_ncycles, no_signal, overrun := 0, all counters 0.
REQ-025 Reset SHALL override every other input same edge, including mid-SETTLE/MEASURE and pending handshake.

Verification
REQ-026 Reset, enable=1, DISCARD=1, meas_done with count_in=20000 twice -> first dropped, second published: result_count=20000, result_ncycles=1, valid one clock later.
REQ-027 MEASURE log_n=0, count_in=5000 -> ncycles_out=2, SETTLE; after discard, count_in=10000 -> ncycles_out=4; count_in=20000 -> published with result_ncycles=4.
REQ-028 log_n=16, count_in=100 -> published, ncycles_out stays 65536; log_n=0, count_in=20000000 -> published, ncycles_out stays 1.
REQ-029 result_ready=0, two in-range publishes -> second data shown, overrun=1; ready=1 -> valid drops next clock; enable 0->1 -> overrun=0.
REQ-030 TIMEOUT=1000, no meas_done for 1000 clocks at log_n=5 -> no_signal=1, ncycles_out=1; next in-range publish -> no_signal=0.
REQ-031 aresetn low during SETTLE with result_valid=1 -> all outputs zero, ncycles_out=1 next clock.

Source files
------------

// File: rtl/freq_range_sequencer.sv
// freq_range_sequencer
//   Sequences a reciprocal frequency counter: picks Ncycles = 1 << log_n so
//   the clock count over Ncycles input periods lands inside
//   [MIN_COUNT, MAX_COUNT], drops DISCARD measurements after each Ncycles
//   change, and publishes in-range (or limit-clamped) counts over a
//   valid/ready handshake.
//
// Ports
//   clk            : single clock, rising edge
//   aresetn        : synchronous active-low reset
//   enable         : run the sequencer; low forces IDLE
//   meas_done      : one-cycle pulse, count_in is fresh this cycle
//   count_in       : clocks counted over the last Ncycles input periods
//   ncycles_out    : Ncycles driven to the counter (1 << log_n)
//   result_count   : published count
//   result_ncycles : Ncycles the published count was taken with
//   result_valid   : published result pending
//   result_ready   : consumer accepts the result
//   no_signal      : no meas_done for TIMEOUT clocks; cleared by next publish
//   overrun        : sticky, an unread result was overwritten
module freq_range_sequencer #(
    parameter int COUNT_WIDTH = 32,
    parameter int LOG_MAX     = 16,
    parameter int INIT_LOG    = 0,
    parameter int MIN_COUNT   = 12500,
    parameter int MAX_COUNT   = 12500000,
    parameter int TIMEOUT     = 125000000,
    parameter int DISCARD     = 1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic                   meas_done,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic [COUNT_WIDTH-1:0] ncycles_out,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic [COUNT_WIDTH-1:0] result_ncycles,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   no_signal,
    output logic                   overrun
);

    localparam int LW = $clog2(LOG_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DISCARD + 2);

    localparam logic [COUNT_WIDTH-1:0] MIN_C  = COUNT_WIDTH'(MIN_COUNT);
    localparam logic [COUNT_WIDTH-1:0] MAX_C  = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [LW-1:0]          LOG_HI = LW'(LOG_MAX);
    localparam logic [LW-1:0]          LOG_0  = LW'(INIT_LOG);
    localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0]          DISC_N = DW'(DISCARD);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;

    state_t                 state_q;
    logic [LW-1:0]          log_n_q;
    logic [COUNT_WIDTH-1:0] ncycles_q;
    logic [DW-1:0]          disc_q;
    logic [TW-1:0]          tmo_q;
    logic [COUNT_WIDTH-1:0] res_count_q;
    logic [COUNT_WIDTH-1:0] res_ncycles_q;
    logic                   res_valid_q;
    logic                   no_signal_q;
    logic                   overrun_q;

    function automatic logic [COUNT_WIDTH-1:0] pow2(input logic [LW-1:0] e);
        return COUNT_WIDTH'(1) << e;
    endfunction

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            log_n_q       <= LOG_0;
            ncycles_q     <= pow2(LOG_0);
            disc_q        <= '0;
            tmo_q         <= '0;
            res_count_q   <= '0;
            res_ncycles_q <= '0;
            res_valid_q   <= 1'b0;
            no_signal_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // Handshake clear; a publish further down overrides it.
            if (res_valid_q && result_ready)
                res_valid_q <= 1'b0;

            if (!enable) begin
                state_q   <= IDLE;
                log_n_q   <= LOG_0;
                ncycles_q <= pow2(LOG_0);
                disc_q    <= '0;
                tmo_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Leaving IDLE with enable high is the enable rising edge.
                        state_q   <= SETTLE;
                        disc_q    <= DISC_N;
                        tmo_q     <= '0;
                        overrun_q <= 1'b0;
                    end
                    SETTLE, MEASURE: begin
                        if (meas_done) begin
                            tmo_q <= '0;
                            if (state_q == SETTLE) begin
                                // Last discard moves straight to MEASURE.
                                if (disc_q <= DW'(1)) begin
                                    disc_q  <= '0;
                                    state_q <= MEASURE;
                                end else begin
                                    disc_q <= disc_q - DW'(1);
                                end
                            end else if (count_in < MIN_C && log_n_q < LOG_HI) begin
                                log_n_q   <= log_n_q + LW'(1);
                                ncycles_q <= pow2(log_n_q + LW'(1));
                                state_q   <= SETTLE;
                                disc_q    <= DISC_N;
                            end else if (count_in > MAX_C && log_n_q != '0) begin
                                log_n_q   <= log_n_q - LW'(1);
                                ncycles_q <= pow2(log_n_q - LW'(1));
                                state_q   <= SETTLE;
                                disc_q    <= DISC_N;
                            end else begin
                                res_count_q   <= count_in;
                                res_ncycles_q <= ncycles_q;
                                res_valid_q   <= 1'b1;
                                no_signal_q   <= 1'b0;
                                if (res_valid_q && !result_ready)
                                    overrun_q <= 1'b1;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            no_signal_q <= 1'b1;
                            log_n_q     <= '0;
                            ncycles_q   <= pow2('0);
                            state_q     <= SETTLE;
                            disc_q      <= DISC_N;
                            tmo_q       <= '0;
                        end else if (state_q == SETTLE && disc_q == '0) begin
                            state_q <= MEASURE;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ncycles_out    = ncycles_q;
    assign result_count   = res_count_q;
    assign result_ncycles = res_ncycles_q;
    assign result_valid   = res_valid_q;
    assign no_signal      = no_signal_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_freq_range_sequencer.sv
// Directed bench for freq_range_sequencer (TIMEOUT overridden to 1000 clocks).
module tb_freq_range_sequencer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        meas_done;
    logic [31:0] count_in;
    logic [31:0] ncycles_out;
    logic [31:0] result_count;
    logic [31:0] result_ncycles;
    logic        result_valid;
    logic        result_ready;
    logic        no_signal;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    freq_range_sequencer #(
        .COUNT_WIDTH(32),
        .LOG_MAX    (16),
        .INIT_LOG   (0),
        .MIN_COUNT  (12500),
        .MAX_COUNT  (12500000),
        .TIMEOUT    (1000),
        .DISCARD    (1)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .enable        (enable),
        .meas_done     (meas_done),
        .count_in      (count_in),
        .ncycles_out   (ncycles_out),
        .result_count  (result_count),
        .result_ncycles(result_ncycles),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .no_signal     (no_signal),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One meas_done pulse; returns on the falling edge after the sampling edge.
    task automatic pulse(input logic [31:0] c);
        @(negedge clk);
        meas_done = 1'b1;
        count_in  = c;
        @(negedge clk);
        meas_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        aresetn      = 1'b0;
        enable       = 1'b0;
        meas_done    = 1'b0;
        count_in     = '0;
        result_ready = 1'b0;
        idle(3);
        check("rst_valid",   {31'd0, result_valid}, 32'd0);
        check("rst_count",   result_count, 32'd0);
        check("rst_ncyc",    result_ncycles, 32'd0);
        check("rst_ncout",   ncycles_out, 32'd1);
        check("rst_nosig",   {31'd0, no_signal}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // First measurement after enable is discarded, second published.
        aresetn = 1'b1;
        enable  = 1'b1;
        idle(2);
        pulse(32'd20000);
        check("discard_valid", {31'd0, result_valid}, 32'd0);
        idle(1);
        pulse(32'd20000);
        check("pub_valid", {31'd0, result_valid}, 32'd1);
        check("pub_count", result_count, 32'd20000);
        check("pub_ncyc",  result_ncycles, 32'd1);

        // Range stepping upward, result left unread -> overrun on next publish.
        pulse(32'd5000);
        check("up1_ncout", ncycles_out, 32'd2);
        pulse(32'd20000);
        pulse(32'd10000);
        check("up2_ncout", ncycles_out, 32'd4);
        pulse(32'd20000);
        check("settle_hold_count", result_count, 32'd20000);
        pulse(32'd20000);
        check("up_pub_count", result_count, 32'd20000);
        check("up_pub_ncyc",  result_ncycles, 32'd4);
        check("overrun_set",  {31'd0, overrun}, 32'd1);

        // Enable drop keeps the pending result; rising edge clears overrun.
        enable = 1'b0;
        idle(2);
        check("idle_ncout",   ncycles_out, 32'd1);
        check("idle_valid",   {31'd0, result_valid}, 32'd1);
        check("idle_count",   result_count, 32'd20000);
        check("idle_overrun", {31'd0, overrun}, 32'd1);
        pulse(32'd30000);
        check("idle_nopub", result_count, 32'd20000);
        enable = 1'b1;
        idle(1);
        check("rise_overrun", {31'd0, overrun}, 32'd0);
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;
        check("hs_valid", {31'd0, result_valid}, 32'd0);

        // Publish on the same edge as a handshake: stays valid, no overrun.
        pulse(32'd20000);
        pulse(32'd25000);
        check("pub2_count", result_count, 32'd25000);
        @(negedge clk);
        result_ready = 1'b1;
        meas_done    = 1'b1;
        count_in     = 32'd26000;
        @(negedge clk);
        meas_done    = 1'b0;
        result_ready = 1'b0;
        check("same_edge_valid",   {31'd0, result_valid}, 32'd1);
        check("same_edge_count",   result_count, 32'd26000);
        check("same_edge_overrun", {31'd0, overrun}, 32'd0);

        // Upper log_n limit: low count published, Ncycles stays 65536.
        result_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pulse(32'd100);
            pulse(32'd100);
        end
        check("max_ncout", ncycles_out, 32'd65536);
        pulse(32'd100);
        check("max_pub_count", result_count, 32'd100);
        check("max_pub_ncyc",  result_ncycles, 32'd65536);
        check("max_ncout_hold", ncycles_out, 32'd65536);

        // Lower limit: high count published, Ncycles stays 1.
        for (int i = 0; i < 16; i++) begin
            pulse(32'd20000000);
            pulse(32'd20000000);
        end
        check("min_ncout", ncycles_out, 32'd1);
        pulse(32'd20000000);
        check("min_pub_count", result_count, 32'd20000000);
        check("min_pub_ncyc",  result_ncycles, 32'd1);
        check("min_ncout_hold", ncycles_out, 32'd1);
        result_ready = 1'b0;

        // Timeout at log_n = 5.
        for (int i = 0; i < 5; i++) begin
            pulse(32'd100);
            pulse(32'd100);
        end
        check("tmo_pre_ncout", ncycles_out, 32'd32);
        n = 0;
        while (!no_signal && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, 32'd1000);
        check("tmo_nosig",  {31'd0, no_signal}, 32'd1);
        check("tmo_ncout",  ncycles_out, 32'd1);
        check("tmo_valid",  {31'd0, result_valid}, 32'd1);
        pulse(32'd20000);
        check("tmo_discard_nosig", {31'd0, no_signal}, 32'd1);
        pulse(32'd20000);
        check("tmo_clear_nosig", {31'd0, no_signal}, 32'd0);
        check("tmo_pub_count",   result_count, 32'd20000);

        // Reset in SETTLE with a pending result, meas_done on the same edge.
        pulse(32'd5000);
        check("pre_rst_ncout", ncycles_out, 32'd2);
        @(negedge clk);
        aresetn   = 1'b0;
        meas_done = 1'b1;
        count_in  = 32'd20000;
        @(negedge clk);
        meas_done = 1'b0;
        check("rst2_valid",   {31'd0, result_valid}, 32'd0);
        check("rst2_count",   result_count, 32'd0);
        check("rst2_ncyc",    result_ncycles, 32'd0);
        check("rst2_ncout",   ncycles_out, 32'd1);
        check("rst2_nosig",   {31'd0, no_signal}, 32'd0);
        check("rst2_overrun", {31'd0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
